// File: rtl/mem_stage.sv
// Memory-access stage: direct-mapped, write-back, write-allocate data cache (one word per line)
// with a miss FSM that stalls upstream stages while it writes back the victim and refills over req/ack.
module mem_stage #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_access,
  input  logic        we_cache_in,
  input  logic        is_word_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] rt_data_in,
  input  logic        register_write_in,
  input  logic [1:0]  register_src_in,
  input  logic [4:0]  rd_num_in,
  output logic        stall,
  output logic        register_write_out,
  output logic [1:0]  register_src_out,
  output logic [4:0]  rd_num_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] mem_data_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FILL} state_t;

  state_t                r_state;
  logic [31:0]           r_data [LINES];
  logic [TAG_W-1:0]      r_tag  [LINES];
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [31:0]           r_miss_addr;

  logic                  r_req;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;

  logic                  r_rw_out;
  logic [1:0]            r_src_out;
  logic [4:0]            r_rd_out;
  logic [31:0]           r_alu_out;
  logic [31:0]           r_data_out;

  logic [1:0]            w_off;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [INDEX_BITS-1:0] w_midx;
  logic [31:0]           w_line;
  logic                  w_hit;
  logic                  w_stall;
  logic                  w_do_hit;
  logic                  w_victim_dirty;
  logic [7:0]            w_byte;
  logic [31:0]           w_load;
  logic [31:0]           w_store_line;

  assign w_off          = ALU_result_in[1:0];
  assign w_idx          = ALU_result_in[INDEX_BITS+1:2];
  assign w_tag          = ALU_result_in[31:INDEX_BITS+2];
  assign w_midx         = r_miss_addr[INDEX_BITS+1:2];
  assign w_line         = r_data[w_idx];
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  assign w_stall        = (r_state != S_IDLE) || (mem_access && !w_hit);
  assign w_do_hit       = (r_state == S_IDLE) && mem_access && w_hit;

  // Little-endian lane select for byte loads and byte-store merge
  always_comb begin
    w_byte       = w_line[7:0];
    w_store_line = w_line;
    case (w_off)
      2'd0: begin w_byte = w_line[7:0];   w_store_line[7:0]   = rt_data_in[7:0]; end
      2'd1: begin w_byte = w_line[15:8];  w_store_line[15:8]  = rt_data_in[7:0]; end
      2'd2: begin w_byte = w_line[23:16]; w_store_line[23:16] = rt_data_in[7:0]; end
      default: begin w_byte = w_line[31:24]; w_store_line[31:24] = rt_data_in[7:0]; end
    endcase
    if (is_word_in) w_store_line = rt_data_in;
    w_load = is_word_in ? w_line : {{24{w_byte[7]}}, w_byte};
  end

  // Data/tag arrays carry no reset; validity alone decides whether they are meaningful
  always_ff @(posedge clk) begin
    if (rst_b) begin
      if (r_state == S_FILL && mem_ack) begin
        r_data[w_midx] <= mem_rdata;
        r_tag[w_midx]  <= r_miss_addr[31:INDEX_BITS+2];
      end else if (w_do_hit && we_cache_in) begin
        r_data[w_idx] <= w_store_line;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_dirty     <= '0;
      r_miss_addr <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_access && !w_hit) begin
            r_miss_addr <= {ALU_result_in[31:2], 2'b00};
            r_req       <= 1'b1;
            if (w_victim_dirty) begin
              r_state <= S_WRITEBACK;
              r_we    <= 1'b1;
              r_addr  <= {r_tag[w_idx], w_idx, 2'b00};
              r_wdata <= w_line;
            end else begin
              r_state <= S_FILL;
              r_we    <= 1'b0;
              r_addr  <= {w_tag, w_idx, 2'b00};
            end
          end else if (w_do_hit && we_cache_in) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          // Request stays up; only address and direction switch over to the fill
          if (mem_ack) begin
            r_dirty[w_midx] <= 1'b0;
            r_state         <= S_FILL;
            r_we            <= 1'b0;
            r_addr          <= r_miss_addr;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_valid[w_midx] <= 1'b1;
            r_dirty[w_midx] <= 1'b0;
            r_state         <= S_IDLE;
            r_req           <= 1'b0;
            r_we            <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Write-back register: bubble while stalled, ALU/load result hold across the bubble
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_rw_out   <= 1'b0;
      r_src_out  <= '0;
      r_rd_out   <= '0;
      r_alu_out  <= '0;
      r_data_out <= '0;
    end else if (w_stall) begin
      r_rw_out  <= 1'b0;
      r_src_out <= '0;
      r_rd_out  <= '0;
    end else begin
      r_rw_out   <= register_write_in;
      r_src_out  <= register_src_in;
      r_rd_out   <= rd_num_in;
      r_alu_out  <= ALU_result_in;
      r_data_out <= (mem_access && !we_cache_in) ? w_load : 32'h0;
    end
  end

  assign stall              = w_stall;
  assign register_write_out = r_rw_out;
  assign register_src_out   = r_src_out;
  assign rd_num_out         = r_rd_out;
  assign ALU_result_out     = r_alu_out;
  assign mem_data_out       = r_data_out;
  assign mem_req            = r_req;
  assign mem_we             = r_we;
  assign mem_addr           = r_addr;
  assign mem_wdata          = r_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: flat architectural memory plus a line-presence model predict load data,
// stall length and request count; a latency-programmable memory responder serves the req/ack port.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_b, mem_access, we_cache_in, is_word_in, register_write_in;
  logic [31:0] ALU_result_in, rt_data_in, mem_rdata;
  logic [1:0]  register_src_in, register_src_out;
  logic [4:0]  rd_num_in, rd_num_out;
  logic        stall, register_write_out, mem_req, mem_we, mem_ack;
  logic [31:0] ALU_result_out, mem_data_out, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_stage #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst_b(rst_b), .mem_access(mem_access), .we_cache_in(we_cache_in),
    .is_word_in(is_word_in), .ALU_result_in(ALU_result_in), .rt_data_in(rt_data_in),
    .register_write_in(register_write_in), .register_src_in(register_src_in),
    .rd_num_in(rd_num_in), .stall(stall), .register_write_out(register_write_out),
    .register_src_out(register_src_out), .rd_num_out(rd_num_out),
    .ALU_result_out(ALU_result_out), .mem_data_out(mem_data_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  int tests = 0, fails = 0;
  int k_wb = 0, k_fill = 0;

  logic [31:0] bk_mem  [int unsigned];   // backing store behind the port
  logic [31:0] ref_mem [int unsigned];   // architectural view the program sees
  bit          mv [16];
  bit          md [16];
  logic [25:0] mt [16];

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  txn_t txq[$];

  function automatic logic [31:0] dflt(logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction
  function automatic logic [31:0] bk_rd(logic [31:0] a);
    int unsigned w = a >> 2;
    return bk_mem.exists(w) ? bk_mem[w] : dflt({a[31:2], 2'b00});
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    int unsigned w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : dflt({a[31:2], 2'b00});
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: acks k cycles after a request is first seen
  initial begin
    bit busy = 0;
    int age = 0;
    txn_t cur;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req !== 1'b1) begin
        busy = 0;
        mem_ack = 1'b0;
      end else begin
        if (!busy) begin
          busy = 1; age = 0;
          cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
          txq.push_back(cur);
          chk("req_align", 32'(mem_addr[1:0]), 32'h0);
        end else begin
          age++;
          chk("req_hold_addr", mem_addr, cur.addr);
          chk("req_hold_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) chk("req_hold_wdata", mem_wdata, cur.wdata);
        end
        if (age == (cur.we ? k_wb : k_fill)) begin
          mem_ack = 1'b1;
          if (cur.we) begin
            bk_mem[cur.addr >> 2] = cur.wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = bk_rd(cur.addr);
          end
          busy = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Runs one instruction from a posedge+1 start to posedge+1 after its completing edge
  task automatic do_op(bit acc, bit st, bit wd, logic [31:0] a, logic [31:0] wdat,
                       bit rw, logic [1:0] src, logic [4:0] rd, output int ns);
    int idx, n, nq0, exp_stall, exp_nreq;
    logic [25:0] tg;
    bit hit, vdirty;
    logic [31:0] exp_data, w;
    logic [7:0] b;
    idx = int'(a[5:2]);
    tg = a[31:6];
    hit = mv[idx] && (mt[idx] == tg);
    vdirty = mv[idx] && md[idx];
    exp_stall = (!acc || hit) ? 0 : (vdirty ? k_wb + k_fill + 3 : k_fill + 2);
    exp_nreq  = (!acc || hit) ? 0 : (vdirty ? 2 : 1);
    exp_data = 32'h0;
    if (acc) begin
      if (!hit) begin mv[idx] = 1; mt[idx] = tg; md[idx] = 0; end
      w = ref_rd(a);
      if (st) begin
        md[idx] = 1;
        if (wd) w = wdat; else w[8*a[1:0] +: 8] = wdat[7:0];
        ref_mem[a >> 2] = w;
      end else if (wd) begin
        exp_data = w;
      end else begin
        b = w[8*a[1:0] +: 8];
        exp_data = {{24{b[7]}}, b};
      end
    end
    nq0 = txq.size();
    mem_access = acc; we_cache_in = st; is_word_in = wd; ALU_result_in = a;
    rt_data_in = wdat; register_write_in = rw; register_src_in = src; rd_num_in = rd;
    n = 0;
    #3;
    while (stall === 1'b1 && n < 300) begin
      n++;
      @(posedge clk); #1;
      chk("bubble", {26'b0, register_write_out, rd_num_out}, 32'h0);
      #3;
    end
    chk($sformatf("stall_cycles@%h", a), 32'(n), 32'(exp_stall));
    chk($sformatf("nreq@%h", a), 32'(txq.size() - nq0), 32'(exp_nreq));
    @(posedge clk); #1;
    chk("rw_out", 32'(register_write_out), 32'(rw));
    chk("rd_out", 32'(rd_num_out), 32'(rd));
    chk("src_out", 32'(register_src_out), 32'(src));
    chk("alu_out", ALU_result_out, a);
    chk($sformatf("data_out@%h", a), mem_data_out, exp_data);
    ns = n;
    mem_access = 0; we_cache_in = 0; register_write_in = 0; rd_num_in = 0;
    register_src_in = 0; ALU_result_in = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int ns, nq, kind;
    logic [31:0] a, d;
    rst_b = 0; mem_access = 0; we_cache_in = 0; is_word_in = 0; ALU_result_in = 0;
    rt_data_in = 0; register_write_in = 0; register_src_in = 0; rd_num_in = 0;
    bk_mem[32'h40 >> 2] = 32'hDEADBEEF;
    ref_mem[32'h40 >> 2] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_rw", 32'(register_write_out), 0);
    chk("rst_alu", ALU_result_out, 0);
    chk("rst_data", mem_data_out, 0);
    chk("rst_addr", mem_addr, 0);
    rst_b = 1;

    // Cold miss, k=0
    k_fill = 0; nq = txq.size();
    do_op(1, 0, 1, 32'h40, 0, 1, 2'd1, 5'd3, ns);
    chk("cold_stall", 32'(ns), 32'd2);
    chk("cold_data", mem_data_out, 32'hDEADBEEF);
    chk("cold_fill_addr", txq[nq].addr, 32'h40);
    chk("cold_fill_we", 32'(txq[nq].we), 0);

    // Byte store then hits
    do_op(1, 1, 0, 32'h41, 32'h80, 0, 2'd0, 5'd0, ns);
    chk("sb_stall", 32'(ns), 0);
    do_op(1, 0, 1, 32'h40, 0, 1, 2'd1, 5'd7, ns);
    chk("lw_merged", mem_data_out, 32'hDEAD80EF);
    do_op(1, 0, 0, 32'h41, 0, 1, 2'd1, 5'd8, ns);
    chk("lb_signext", mem_data_out, 32'hFFFFFF80);

    // Dirty conflict miss
    k_wb = 0; k_fill = 0; nq = txq.size();
    do_op(1, 0, 1, 32'h80, 0, 1, 2'd1, 5'd9, ns);
    chk("dirty_stall", 32'(ns), 32'd3);
    chk("wb_we", 32'(txq[nq].we), 1);
    chk("wb_addr", txq[nq].addr, 32'h40);
    chk("wb_data", txq[nq].wdata, 32'hDEAD80EF);
    chk("fill2_addr", txq[nq+1].addr, 32'h80);
    chk("bk_written", bk_rd(32'h40), 32'hDEAD80EF);

    // Slow fill
    k_fill = 3;
    do_op(1, 0, 1, 32'hC4, 0, 1, 2'd1, 5'd10, ns);
    chk("slow_stall", 32'(ns), 32'd5);

    // Non-memory instruction
    do_op(0, 0, 1, 32'h1234, 0, 1, 2'd0, 5'd5, ns);
    chk("nonmem_alu", ALU_result_out, 32'h1234);
    chk("nonmem_rd", 32'(rd_num_out), 32'd5);

    // Reset in the middle of a fill
    k_fill = 6;
    mem_access = 1; we_cache_in = 0; is_word_in = 1; ALU_result_in = 32'h08;
    register_write_in = 1; rd_num_in = 5'd4;
    #3; chk("rf_stall", 32'(stall), 1);
    @(posedge clk); #1;
    chk("rf_req", 32'(mem_req), 1);
    chk("rf_addr", mem_addr, 32'h08);
    @(posedge clk); #1;
    mem_access = 0; register_write_in = 0; rd_num_in = 0; ALU_result_in = 0; rst_b = 0;
    @(posedge clk); #1;
    rst_b = 1;
    chk("rf_req_drop", 32'(mem_req), 0);
    chk("rf_we", 32'(mem_we), 0);
    chk("rf_maddr", mem_addr, 0);
    chk("rf_wdata", mem_wdata, 0);
    chk("rf_alu", ALU_result_out, 0);
    chk("rf_rw", 32'(register_write_out), 0);
    #3; chk("rf_stall_low", 32'(stall), 0);
    #2; @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin mv[i] = 0; md[i] = 0; end
    ref_mem = bk_mem;
    k_fill = 1;
    do_op(1, 0, 1, 32'h08, 0, 1, 2'd1, 5'd4, ns);
    chk("reload_miss", 32'(ns), 32'd3);

    // Randomized mix over 4 tags x 16 indices
    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 4);
      a = $urandom & 32'hFC;
      if (kind == 2 || kind == 4) a[1:0] = 2'($urandom_range(0, 3));
      d = $urandom;
      k_wb = $urandom_range(0, 3);
      k_fill = $urandom_range(0, 3);
      case (kind)
        0: do_op(0, 0, 1, $urandom, d, 1'($urandom), 2'($urandom), 5'($urandom), ns);
        1: do_op(1, 0, 1, a, d, 1'($urandom), 2'($urandom), 5'($urandom), ns);
        2: do_op(1, 0, 0, a, d, 1'($urandom), 2'($urandom), 5'($urandom), ns);
        3: do_op(1, 1, 1, a, d, 1'($urandom), 2'($urandom), 5'($urandom), ns);
        default: do_op(1, 1, 0, a, d, 1'($urandom), 2'($urandom), 5'($urandom), ns);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
